// File: rtl/memory_access_pkg.sv
// Shared constants, opcode map and helpers for the memory-access pipeline stage.
package memory_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned BE_W   = 4;

    // Opcode lives in instruction[OPC_W-1:0]; LD/SD are the byte-sized accesses.
    localparam logic [OPC_W-1:0] OP_ADD = 6'h00;
    localparam logic [OPC_W-1:0] OP_LD  = 6'h20;
    localparam logic [OPC_W-1:0] OP_LH  = 6'h21;
    localparam logic [OPC_W-1:0] OP_LW  = 6'h23;
    localparam logic [OPC_W-1:0] OP_SD  = 6'h28;
    localparam logic [OPC_W-1:0] OP_SH  = 6'h29;
    localparam logic [OPC_W-1:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    function automatic size_e op_size(input logic [OPC_W-1:0] op);
        case (op)
            OP_LD, OP_SD: return SZ_BYTE;
            OP_LH, OP_SH: return SZ_HALF;
            OP_LW, OP_SW: return SZ_WORD;
            default:      return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [OPC_W-1:0] op);
        return (op == OP_SD) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
        return ((sz == SZ_WORD) && (lane != 2'b00)) || ((sz == SZ_HALF) && lane[0]);
    endfunction

    function automatic logic [BE_W-1:0] lane_mask(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Selects the addressed byte/half lane of load data and sign-extends it.
module memory_access_load_align
    import memory_access_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       lane,
    input  size_e            size,
    output logic [WIDTH-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data_c = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            SZ_HALF: data_c = {{(WIDTH-16){half_sel[15]}}, half_sel};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: pass-through for ALU ops, request/response
// sequencing with alignment and timeout faults for loads and stores.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] instruction_in,
    input  logic [WIDTH-3:0] progcounter_in,
    input  logic [WIDTH-1:0] dataC,
    input  logic [WIDTH-1:0] addr,
    output logic             IsStall,
    output logic [WIDTH-1:0] instruction_out,
    output logic [WIDTH-3:0] progcounter_out,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_valid,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [BE_W-1:0]  mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    size_e            size_q, size_d;
    logic [1:0]       lane_q, lane_d;

    logic             stall_d, wb_valid_d, req_d, we_d, fault_d;
    logic [WIDTH-1:0] instr_d, wb_data_d, maddr_d, wdata_d;
    logic [WIDTH-3:0] pc_d;
    logic [BE_W-1:0]  be_d;

    logic             accept;
    size_e            in_size;
    logic [WIDTH-1:0] load_data_c;

    memory_access_load_align #(.WIDTH(WIDTH)) u_load_align (
        .rdata  (mem_rdata),
        .lane   (lane_q),
        .size   (size_q),
        .data_c (load_data_c)
    );

    // Next-state and next-output logic; every output below is registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        lane_d     = lane_q;
        stall_d    = IsStall;
        instr_d    = instruction_out;
        pc_d       = progcounter_out;
        wb_data_d  = wb_data;
        wb_valid_d = 1'b0;
        req_d      = mem_req;
        we_d       = mem_we;
        maddr_d    = mem_addr;
        wdata_d    = mem_wdata;
        be_d       = mem_be;
        fault_d    = 1'b0;

        accept  = in_valid && !IsStall;
        in_size = op_size(instruction_in[OPC_W-1:0]);

        case (state_q)
            ST_ACCESS: begin
                // An ack on the timeout cycle still completes normally.
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    stall_d    = 1'b0;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mem_we ? '0 : load_data_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = ST_RESP;
                    stall_d    = 1'b0;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    fault_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // RESP has no stall, so it accepts exactly like IDLE.
                state_d = ST_IDLE;
                if (accept) begin
                    instr_d = instruction_in;
                    pc_d    = progcounter_in;
                    if (in_size == SZ_NONE) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = dataC;
                    end else if (misaligned(in_size, addr[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        fault_d    = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                        size_d  = in_size;
                        lane_d  = addr[1:0];
                        stall_d = 1'b1;
                        req_d   = 1'b1;
                        we_d    = op_is_store(instruction_in[OPC_W-1:0]);
                        maddr_d = {addr[WIDTH-1:2], 2'b00};
                        be_d    = lane_mask(in_size, addr[1:0]);
                        case (in_size)
                            SZ_BYTE: wdata_d = {(WIDTH/8){dataC[7:0]}};
                            SZ_HALF: wdata_d = {(WIDTH/16){dataC[15:0]}};
                            default: wdata_d = dataC;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            size_q          <= SZ_NONE;
            lane_q          <= 2'b00;
            IsStall         <= 1'b0;
            instruction_out <= '0;
            progcounter_out <= '0;
            wb_data         <= '0;
            wb_valid        <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_be          <= '0;
            mem_fault       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            size_q          <= size_d;
            lane_q          <= lane_d;
            IsStall         <= stall_d;
            instruction_out <= instr_d;
            progcounter_out <= pc_d;
            wb_data         <= wb_data_d;
            wb_valid        <= wb_valid_d;
            mem_req         <= req_d;
            mem_we          <= we_d;
            mem_addr        <= maddr_d;
            mem_wdata       <= wdata_d;
            mem_be          <= be_d;
            mem_fault       <= fault_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Randomized and directed checks of memory_access against a lane-arithmetic reference model.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  instruction_in = '0;
    logic [W-3:0]  progcounter_in = '0;
    logic [W-1:0]  dataC = '0;
    logic [W-1:0]  addr = '0;
    logic          IsStall;
    logic [W-1:0]  instruction_out;
    logic [W-3:0]  progcounter_out;
    logic [W-1:0]  wb_data;
    logic          wb_valid;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack = 1'b0;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_fault;

    int n_total = 0;
    int n_pass  = 0;

    memory_access #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .instruction_in  (instruction_in),
        .progcounter_in  (progcounter_in),
        .dataC           (dataC),
        .addr            (addr),
        .IsStall         (IsStall),
        .instruction_out (instruction_out),
        .progcounter_out (progcounter_out),
        .wb_data         (wb_data),
        .wb_valid        (wb_valid),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_fault       (mem_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Access size in bytes; 0 means the opcode does not touch memory.
    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_SH) return 2;
        if (op == OP_LD || op == OP_SD) return 1;
        return 0;
    endfunction

    // Issue one instruction; ack_at is the ACCESS cycle that carries mem_ack (0 = never).
    task automatic run_txn(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] d,
                           input int ack_at, input logic [W-1:0] rd);
        int           nb, off, stalls;
        bit           is_st, acked;
        logic [W-1:0] instr, wd_e, wb_e, mask;
        logic [W-3:0] pc;
        logic [3:0]   be_e;

        nb    = op_bytes(op);
        off   = int'(a % 4);
        is_st = (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
        instr = $urandom;
        instr[5:0] = op;
        pc    = (W-2)'($urandom);

        @(negedge clk);
        check("accept_stall", W'(IsStall), '0);
        in_valid       = 1'b1;
        instruction_in = instr;
        progcounter_in = pc;
        dataC          = d;
        addr           = a;
        mem_ack        = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        check("instr_out", instruction_out, instr);
        check("pc_out", W'(progcounter_out), W'(pc));

        if (nb == 0) begin
            check("pass_wb_valid", W'(wb_valid), 1);
            check("pass_wb_data", wb_data, d);
            check("pass_req", W'(mem_req), 0);
            check("pass_fault", W'(mem_fault), 0);
        end else if (off % nb != 0) begin
            check("mis_req", W'(mem_req), 0);
            check("mis_fault", W'(mem_fault), 1);
            check("mis_wb_valid", W'(wb_valid), 1);
            check("mis_wb_data", wb_data, 0);
        end else begin
            be_e = 4'(((1 << nb) - 1) << off);
            for (int l = 0; l < 4; l++) wd_e[8*l +: 8] = d[8*(l % nb) +: 8];
            check("req_on", W'(mem_req), 1);
            check("mem_we", W'(mem_we), W'(is_st));
            check("mem_be", W'(mem_be), W'(be_e));
            check("mem_addr", mem_addr, a & ~W'(3));
            if (is_st) check("mem_wdata", mem_wdata, wd_e);
            stalls = 0;
            acked  = 0;
            for (int k = 1; k <= TO && !acked; k++) begin
                if (k > 1) begin
                    check("req_held", W'(mem_req), 1);
                    check("addr_held", mem_addr, a & ~W'(3));
                end
                if (IsStall) stalls++;
                check("access_no_wb", W'(wb_valid), 0);
                if (k == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                    acked     = 1;
                end
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (!acked || is_st) begin
                wb_e = '0;
            end else begin
                wb_e = rd >> (8 * off);
                if (nb < 4) begin
                    mask = (W'(1) << (8 * nb)) - W'(1);
                    wb_e = wb_e & mask;
                    if (wb_e[8*nb-1]) wb_e = wb_e | ~mask;
                end
            end
            check("stall_cycles", W'(stalls), acked ? W'(ack_at) : W'(TO));
            check("resp_stall", W'(IsStall), 0);
            check("resp_req", W'(mem_req), 0);
            check("resp_wb_valid", W'(wb_valid), 1);
            check("resp_wb_data", wb_data, wb_e);
            check("resp_fault", W'(mem_fault), W'(!acked));
        end
        @(negedge clk);
        check("wb_one_cycle", W'(wb_valid), 0);
        check("fault_one_cycle", W'(mem_fault), 0);
    endtask

    logic [5:0] ops [8];

    initial begin
        ops = '{OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD, OP_ADD, 6'h05};

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        check("rst_stall", W'(IsStall), 0);
        check("rst_wb_valid", W'(wb_valid), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_req", W'(mem_req), 0);
        check("rst_be", W'(mem_be), 0);
        check("rst_fault", W'(mem_fault), 0);
        check("rst_instr", instruction_out, 0);
        rst_n = 1'b1;

        run_txn(OP_LW,  32'h0000_0100, 32'h0,         3,  32'hDEAD_BEEF);
        run_txn(OP_LD,  32'h0000_0103, 32'h0,         2,  32'h8000_0000);
        run_txn(OP_SH,  32'h0000_0102, 32'h1234_ABCD, 1,  32'h0);
        run_txn(OP_LW,  32'h0000_0101, 32'h0,         1,  32'h0);
        run_txn(OP_LW,  32'h0000_0200, 32'h0,         0,  32'h0);
        run_txn(OP_LW,  32'h0000_0204, 32'h0,         16, 32'hCAFE_F00D);
        run_txn(OP_ADD, 32'h0000_0000, 32'h0000_0007, 0,  32'h0);
        run_txn(OP_LH,  32'h0000_0302, 32'h0,         2,  32'h9ABC_1234);
        run_txn(OP_SD,  32'h0000_0301, 32'h0000_00A5, 1,  32'h0);
        run_txn(OP_SH,  32'h0000_0301, 32'h0000_5555, 1,  32'h0);

        // Reset mid-ACCESS discards the access
        @(negedge clk);
        in_valid       = 1'b1;
        instruction_in = W'(OP_LW);
        addr           = 32'h0000_0400;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_req", W'(mem_req), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", W'(mem_req), 0);
        check("rst_mid_stall", W'(IsStall), 0);
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_wb", W'(wb_valid), 0);
            check("post_rst_no_req", W'(mem_req), 0);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int ack_at;
            ack_at = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 16));
            run_txn(ops[$urandom_range(0, 7)], $urandom, $urandom, ack_at, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the datapath width.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles to wait for mem_ack.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, which marks a valid instruction from the execute stage.
REQ-006 SHALL have ports instruction_in (input, WIDTH) and progcounter_in (input, WIDTH-2), the execute-stage instruction and PC.
REQ-007 SHALL have ports dataC (input, WIDTH) and addr (input, WIDTH): ALU result or store data, and effective address.
REQ-008 SHALL have port IsStall, output, 1 bit, the stall request to the execute stage.
REQ-009 SHALL have ports instruction_out (output, WIDTH) and progcounter_out (output, WIDTH-2), registered to writeback.
REQ-010 SHALL have ports wb_data (output, WIDTH) and wb_valid (output, 1), the writeback data and its qualifier.
REQ-011 SHALL have ports mem_req, mem_we (output, 1), mem_addr, mem_wdata (output, WIDTH) and mem_be (output, 4), the data-memory request.
REQ-012 SHALL have ports mem_ack (input, 1) and mem_rdata (input, WIDTH), the data-memory response.
REQ-013 SHALL have port mem_fault, output, 1 bit, a one-cycle pulse on misalignment or timeout.

Function
REQ-014 SHALL accept an instruction when in_valid=1 and IsStall=0; otherwise the inputs are ignored.
REQ-015 SHALL treat a non-memory opcode (anything other than LW/LH/LD/SW/SH/SD) as pass-through: one cycle after acceptance, wb_valid=1, wb_data=dataC, and instruction/PC forwarded.
REQ-016 SHALL use the FSM states IDLE, ACCESS and RESP. IDLE goes to ACCESS on acceptance of an aligned memory opcode. ACCESS goes to RESP on mem_ack or on timeout. RESP goes to IDLE unconditionally.
REQ-017 SHALL hold mem_req=1 and all mem_* outputs stable throughout ACCESS; mem_req=0 in every other state.
REQ-018 SHALL drive IsStall=1 whenever the state is ACCESS, including the cycle in which mem_ack arrives; IsStall=0 in IDLE and RESP.
REQ-019 SHALL use little-endian byte lanes: LW/SW mem_be=4'b1111; LH/SH mem_be=4'b0011<<addr[1:0]; LD/SD (byte) mem_be=4'b0001<<addr[1:0].
REQ-020 SHALL set mem_addr={addr[WIDTH-1:2],2'b00}, and mem_we=1 for stores only.
REQ-021 SHALL replicate store data across lanes: a byte store replicates dataC[7:0] ×4, a half store dataC[15:0] ×2, a word store uses dataC unchanged.
REQ-022 SHALL sign-extend LH and LD loads from the lane selected by addr[1:0]; LW returns mem_rdata unchanged.
REQ-023 SHALL capture mem_rdata on the mem_ack cycle and present wb_valid=1 with the load result in RESP; a store in RESP gives wb_valid=1, wb_data=0.
REQ-024 SHALL treat LW/SW with addr[1:0]≠0, and LH/SH with addr[0]=1, as misaligned: no mem_req, a mem_fault pulse, and wb_valid=1, wb_data=0 the next cycle.
REQ-025 SHALL count ACCESS cycles with a counter cleared on entry. When the count reaches TIMEOUT with no ack, mem_req drops, mem_fault pulses, and RESP gives wb_data=0.
REQ-026 SHALL let mem_ack win when it arrives on the same cycle as timeout: a normal completion, no fault.
REQ-027 SHALL ignore mem_ack outside ACCESS.
REQ-028 SHALL hold wb_valid high for exactly one cycle per accepted instruction.

Reset
REQ-029 SHALL, while rst_n=0, force the state to IDLE and all outputs to 0, with the counter cleared.
REQ-030 SHALL, on reset asserted mid-ACCESS, drop mem_req immediately and discard the pending access, producing no wb_valid.

Structure
REQ-031 SHALL place WIDTH, the opcode constants and the FSM state encoding in the shared parameter/instruction-set includes.
REQ-032 SHALL split out one sub-module, load_align, for combinational lane select and sign-extend of load data.

Verification
REQ-033 SHALL cover: LW addr=0x100, mem_ack after 3 cycles with rdata=0xDEADBEEF -> IsStall high 3 cycles, wb_data=0xDEADBEEF, mem_be=1111.
REQ-034 SHALL cover: LD addr=0x103, rdata=0x80000000 -> mem_be=1000, wb_data=0xFFFFFF80.
REQ-035 SHALL cover: SH addr=0x102, dataC=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD.
REQ-036 SHALL cover: LW addr=0x101 -> no mem_req, mem_fault pulse, wb_valid with wb_data=0.
REQ-037 SHALL cover: LW with mem_ack never asserted -> mem_fault after 16 ACCESS cycles; then a repeat with ack on cycle 16 -> normal completion, no fault.
REQ-038 SHALL cover: ADD with dataC=7 -> wb_valid next cycle with wb_data=7; then rst_n low mid-ACCESS -> mem_req 0 immediately and no wb_valid.
